// File: rtl/prim_diff_decode_pkg.sv
// Shared types and widths for the multi-channel differential decoder.
package prim_diff_decode_pkg;

  typedef enum logic [1:0] {
    IsStd    = 2'b00,
    IsSkewed = 2'b01,
    SigInt   = 2'b10
  } diff_state_e;

  localparam int ErrCntW  = 8;
  localparam int SkewCntW = 4;

endpackage

// File: rtl/prim_diff_decode_chan.sv
// One differential channel: synchroniser, skew-tolerant decode FSM, fault counter.
// Fault counter is built only when DIFF_DECODE_ERR_CNT_EN is defined.
module prim_diff_decode_chan
  import prim_diff_decode_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int SkewCycles = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               diff_pi,
  input  logic               diff_ni,
  input  logic               err_clr_i,
  output logic               level_o,
  output logic               rise_o,
  output logic               fall_o,
  output logic               sigint_o,
  output logic [ErrCntW-1:0] err_cnt_o
);

  localparam logic [SkewCntW-1:0] SkewMax = SkewCntW'(SkewCycles);

  logic [SyncStages-1:0] p_sync_q, n_sync_q;
  logic                  diff_pq, diff_nq, level_q, level_d;
  logic                  p, n, pe, ne, ok;
  logic [SkewCntW-1:0]   skew_cnt_q, skew_cnt_d;
  diff_state_e           state_q, state_d;

  // n chain resets high so the idle pair reads as a clean 0 level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_sync_q   <= '0;
      n_sync_q   <= '1;
      diff_pq    <= 1'b0;
      diff_nq    <= 1'b1;
      level_q    <= 1'b0;
      skew_cnt_q <= '0;
      state_q    <= IsStd;
    end else begin
      p_sync_q   <= {p_sync_q[SyncStages-2:0], diff_pi};
      n_sync_q   <= {n_sync_q[SyncStages-2:0], diff_ni};
      diff_pq    <= p;
      diff_nq    <= n;
      level_q    <= level_d;
      skew_cnt_q <= skew_cnt_d;
      state_q    <= state_d;
    end
  end

  assign p  = p_sync_q[SyncStages-1];
  assign n  = n_sync_q[SyncStages-1];
  assign pe = p ^ diff_pq;
  assign ne = n ^ diff_nq;
  assign ok = p ^ n;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    skew_cnt_d = '0;
    rise_o     = 1'b0;
    fall_o     = 1'b0;
    sigint_o   = 1'b0;
    case (state_q)
      IsStd: begin
        if (ok) begin
          level_d = p;
          if (pe && ne) begin
            rise_o = p;
            fall_o = ~p;
          end
        end else if (pe || ne) begin
          state_d    = IsSkewed;
          skew_cnt_d = SkewCntW'(1);
        end else begin
          state_d  = SigInt;
          sigint_o = 1'b1;
        end
      end
      IsSkewed: begin
        if (ok) begin
          state_d = IsStd;
          level_d = p;
          // a skew that settles back to the old polarity is not an event
          if (p != level_q) begin
            rise_o = p;
            fall_o = ~p;
          end
        end else if (skew_cnt_q < SkewMax) begin
          skew_cnt_d = skew_cnt_q + SkewCntW'(1);
        end else begin
          state_d  = SigInt;
          sigint_o = 1'b1;
        end
      end
      SigInt: begin
        if (ok) begin
          state_d = IsStd;
          level_d = p;
        end else begin
          sigint_o = 1'b1;
        end
      end
      default: begin
        state_d  = SigInt;
        sigint_o = 1'b1;
      end
    endcase
  end

  assign level_o = level_d;

`ifdef DIFF_DECODE_ERR_CNT_EN
  logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
    end else if (state_d == SigInt && state_q != SigInt && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ErrCntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_cnt_o      = '0;
`endif

endmodule

// File: rtl/prim_diff_decode_multi.sv
// NumChan independent differential decoders with an OR'd integrity summary.
// Optional per-channel fault counters: DIFF_DECODE_ERR_CNT_EN.
module prim_diff_decode_multi
  import prim_diff_decode_pkg::*;
#(
  parameter int NumChan    = 4,
  parameter int SyncStages = 2,
  parameter int SkewCycles = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumChan-1:0]               diff_pi,
  input  logic [NumChan-1:0]               diff_ni,
  output logic [NumChan-1:0]               level_o,
  output logic [NumChan-1:0]               rise_o,
  output logic [NumChan-1:0]               fall_o,
  output logic [NumChan-1:0]               event_o,
  output logic [NumChan-1:0]               sigint_o,
  output logic                             sigint_any_o,
  input  logic                             err_clr_i,
  output logic [NumChan-1:0][ErrCntW-1:0]  err_cnt_o
);

  for (genvar gi = 0; gi < NumChan; gi++) begin : g_chan
    prim_diff_decode_chan #(
      .SyncStages(SyncStages),
      .SkewCycles(SkewCycles)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .diff_pi  (diff_pi[gi]),
      .diff_ni  (diff_ni[gi]),
      .err_clr_i(err_clr_i),
      .level_o  (level_o[gi]),
      .rise_o   (rise_o[gi]),
      .fall_o   (fall_o[gi]),
      .sigint_o (sigint_o[gi]),
      .err_cnt_o(err_cnt_o[gi])
    );
  end

  assign event_o      = rise_o | fall_o;
  assign sigint_any_o = |sigint_o;

endmodule

// File: tb/tb_prim_diff_decode_multi.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a behavioural
// model; an independent monitor pops and compares every clock.
module tb_prim_diff_decode_multi;
  localparam int N  = 4;
  localparam int SS = 2;
  localparam int SK = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       dp, dn;
  logic               clr;
  logic [N-1:0]       level, rise, fall, evt, sigint;
  logic               sigint_any;
  logic [N-1:0][7:0]  err_cnt;

  prim_diff_decode_multi #(.NumChan(N), .SyncStages(SS), .SkewCycles(SK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .diff_pi(dp), .diff_ni(dn),
    .level_o(level), .rise_o(rise), .fall_o(fall), .event_o(evt),
    .sigint_o(sigint), .sigint_any_o(sigint_any),
    .err_clr_i(clr), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]      level, rise, fall, sigint;
    logic [N-1:0][7:0] cnt;
  } exp_t;

  exp_t         exp_q[$];
  int           errors = 0, checks = 0;
  bit           mon_en = 0;
  logic [N-1:0] cp, cn;

  // model: last good polarity, run length of p==n samples, fault flag
  logic [N-1:0] m_lvl, m_fault, m_ent;
  int           m_bad[N];
  int           m_cnt[N];
  logic [N-1:0] dl_p[$], dl_n[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_fault = '0; m_ent = '0;
    for (int i = 0; i < N; i++) begin m_bad[i] = 0; m_cnt[i] = 0; end
    dl_p.delete(); dl_n.delete();
    for (int i = 0; i < SS - 1; i++) begin dl_p.push_back('0); dl_n.push_back('1); end
  endtask

  // called at a negedge: drive, predict the cycle after the coming edge, wait
  task automatic step(input logic [N-1:0] p, input logic [N-1:0] n, input logic c);
    exp_t e;
    logic [N-1:0] sp, sn;
    dp = p; dn = n; clr = c; cp = p; cn = n;
    for (int i = 0; i < N; i++) begin
      if (c) m_cnt[i] = 0;
      else if (m_ent[i] && m_cnt[i] < 255) m_cnt[i]++;
    end
    dl_p.push_back(p); dl_n.push_back(n);
    sp = dl_p.pop_front(); sn = dl_n.pop_front();
    e.rise = '0; e.fall = '0;
    for (int i = 0; i < N; i++) begin
      m_ent[i] = 1'b0;
      if (sp[i] != sn[i]) begin
        if (m_fault[i]) m_fault[i] = 1'b0;
        else if (sp[i] != m_lvl[i]) begin
          if (sp[i]) e.rise[i] = 1'b1; else e.fall[i] = 1'b1;
        end
        m_lvl[i] = sp[i];
        m_bad[i] = 0;
      end else begin
        m_bad[i]++;
        if (!m_fault[i] && m_bad[i] > SK) begin
          m_fault[i] = 1'b1;
          m_ent[i]   = 1'b1;
        end
      end
      e.level[i]  = m_lvl[i];
      e.sigint[i] = m_fault[i];
`ifdef DIFF_DECODE_ERR_CNT_EN
      e.cnt[i] = 8'(m_cnt[i]);
`else
      e.cnt[i] = '0;
`endif
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold(input int k);
    for (int j = 0; j < k; j++) step(cp, cn, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_event"}, 32'(rise | fall | evt), 0);
    chk({tag, "_sigint"}, 32'({sigint, sigint_any}), 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    rst_n = 1'b0; dp = '0; dn = '1; clr = 1'b0; cp = '0; cn = '1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    model_reset();
    exp_q.delete();
    rst_n = 1'b1;
    mon_en = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("level", 32'(level), 32'(e.level));
          chk("rise", 32'(rise), 32'(e.rise));
          chk("fall", 32'(fall), 32'(e.fall));
          chk("event", 32'(evt), 32'(e.rise | e.fall));
          chk("sigint", 32'(sigint), 32'(e.sigint));
          chk("sigint_any", 32'(sigint_any), 32'(|e.sigint));
          chk("err_cnt", 32'(err_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    do_reset();
    // steady idle, then ch2 flips cleanly
    hold(4);
    step(4'b0100, 4'b1011, 1'b0); hold(4);
    // ch0: skew of 2 cycles tolerated, then back to 0 the same way
    step(4'b0101, 4'b1011, 1'b0); hold(1);
    step(4'b0101, 4'b1010, 1'b0); hold(3);
    step(4'b0100, 4'b1010, 1'b0); hold(1);
    step(4'b0100, 4'b1011, 1'b0); hold(3);
    // ch0: skew of 3 cycles -> fault for one cycle, no rise
    step(4'b0101, 4'b1011, 1'b0); hold(2);
    step(4'b0101, 4'b1010, 1'b0); hold(3);
    // ch1: skew then revert
    step(4'b0111, 4'b1010, 1'b0);
    step(4'b0101, 4'b1010, 1'b0); hold(3);
    // ch3: p=n=1 for 10 cycles, then restore 1/0
    step(4'b1101, 4'b1010, 1'b0); hold(9);
    step(4'b1101, 4'b0010, 1'b0); hold(4);
    // simultaneous events on all channels
    step(4'b0010, 4'b1101, 1'b0); hold(3);
    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [N-1:0] p, n;
      p = cp; n = cn;
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 9))
          5, 6: begin p[i] = ~p[i]; n[i] = ~n[i]; end
          7: p[i] = ~p[i];
          8: n[i] = ~n[i];
          9: begin p[i] = 1'($urandom); n[i] = 1'($urandom); end
          default: ;
        endcase
      end
      step(p, n, ($urandom_range(0, 49) == 0));
    end
    // clean level, then 300 fault entries on every channel
    step('1, '0, 1'b1); hold(4);
    for (int k = 0; k < 300; k++) begin
      step('1, '1, 1'b0); hold(3);
      step('1, '0, 1'b0);
    end
    hold(3);
    step(cp, cn, 1'b1); hold(3);
    // enter a fault, then async reset mid-fault
    step('1, '1, 1'b0); hold(4);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    do_reset();
    hold(5);
    step(4'b1000, 4'b0111, 1'b0); hold(4);
    chk("queue_drained", 32'(exp_q.size()), 0);
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
